// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Includes the opcode width, the NOP opcode and the payload width of each stage boundary.
package pipe_pkg;

  localparam int DEF_CODE_W = 6;
  localparam logic [DEF_CODE_W-1:0] OP_NOP = 6'd0;

  localparam int IF_ID_W   = 64;
  localparam int ID_RF_W   = 96;
  localparam int RF_ALU_W  = 128;
  localparam int ALU_MEM_W = 112;
  localparam int MEM_WB_W  = 72;

endpackage

// File: rtl/pipe_slot.sv
// One entry of a pipeline stage: a valid bit, an opcode and a payload.
// It has a load/clear interface. The payload survives a clear, so a hold-last-value output is possible.
module pipe_slot #(
  parameter int CODE_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [CODE_W-1:0] ld_code,
  input  logic [DATA_W-1:0] ld_data,
  output logic              v,
  output logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= 1'b0;
      code <= '0;
      data <= '0;
    end else if (clr) begin
      v <= 1'b0;
    end else if (ld) begin
      v    <= 1'b1;
      code <= ld_code;
      data <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer.
// in_ready is registered. The stage also supports flush with bubble insertion and counts stall cycles with saturation.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                CODE_W      = DEF_CODE_W,
  parameter int                DATA_W      = 64,
  parameter logic [CODE_W-1:0] NOP_CODE    = OP_NOP,
  parameter bit                ZERO_BUBBLE = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_v, s_v;
  logic [CODE_W-1:0] m_code, s_code;
  logic [DATA_W-1:0] m_data, s_data;

  logic              acc, dlv, m_free;
  logic              m_ld, m_clr, m_from_skid;
  logic              s_ld, s_clr, s_v_next;
  logic [CODE_W-1:0] m_ld_code;
  logic [DATA_W-1:0] m_ld_data;

  assign acc    = in_valid & in_ready;
  assign dlv    = m_v & out_ready;
  assign m_free = ~m_v | dlv;

  always_comb begin
    m_ld        = 1'b0;
    m_clr       = 1'b0;
    m_from_skid = 1'b0;
    s_ld        = 1'b0;
    s_clr       = 1'b0;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (m_free) begin
      if (s_v) begin
        m_ld        = 1'b1;
        m_from_skid = 1'b1;
        if (acc) s_ld  = 1'b1;
        else     s_clr = 1'b1;
      end else if (acc) begin
        m_ld = 1'b1;
      end else begin
        m_clr = 1'b1;
      end
    end else if (acc) begin
      s_ld = 1'b1;
    end
  end

  // The skid entry always moves ahead of a newer input, which keeps the order intact.
  assign m_ld_code = m_from_skid ? s_code : in_code;
  assign m_ld_data = m_from_skid ? s_data : in_data;
  assign s_v_next  = s_ld | (s_v & ~s_clr);

  pipe_slot #(.CODE_W(CODE_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr     (m_clr),
    .ld      (m_ld),
    .ld_code (m_ld_code),
    .ld_data (m_ld_data),
    .v       (m_v),
    .code    (m_code),
    .data    (m_data)
  );

  pipe_slot #(.CODE_W(CODE_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (s_clr),
    .ld      (s_ld),
    .ld_code (in_code),
    .ld_data (in_data),
    .v       (s_v),
    .code    (s_code),
    .data    (s_data)
  );

  // Ready drops only when the skid slot is occupied, so an accepted entry always has a place to go.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= ~s_v_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (m_v && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign out_valid = m_v;
  assign out_code  = m_v ? m_code : NOP_CODE;
  assign out_data  = (m_v || !ZERO_BUBBLE) ? m_data : '0;

endmodule
